// File: rtl/frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_sequencer                                                 |
// | Brief    : Clears the back buffer, runs the rasterizer, swaps on vsync.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module frame_sequencer #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_req,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               gpu_start,
    input  logic               gpu_done,
    input  logic [ADDR_W-1:0]  gpu_addr,
    input  logic               gpu_wen,
    input  logic [COLOR_W-1:0] gpu_dout,
    input  logic               vsync,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic               fb_wen,
    output logic [COLOR_W-1:0] fb_dout,
    output logic               fb_sel,
    output logic               disp_sel,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [ADDR_W:0]   c_N    = (ADDR_W+1)'(WIDTH*HEIGHT);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(WIDTH*HEIGHT-1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_START     = 3'd2,
        S_RENDER    = 3'd3,
        S_SWAP_WAIT = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_clr_addr, w_clr_addr_nxt;
    logic [ADDR_W-1:0]  r_fb_addr, w_fb_addr_nxt;
    logic               r_fb_wen, w_fb_wen_nxt;
    logic [COLOR_W-1:0] r_fb_dout, w_fb_dout_nxt;
    logic               r_gpu_start, w_gpu_start_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               r_fb_sel, w_fb_sel_nxt;
    logic               r_pending, w_pending_nxt;
    logic               r_done_q;
    logic               r_vsync_q;
    logic               w_done_rise;
    logic               w_vsync_rise;
    logic               w_busy;

    assign w_done_rise  = gpu_done & ~r_done_q;
    assign w_vsync_rise = vsync & ~r_vsync_q;
    assign w_busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_clr_addr   <= '0;
            r_fb_addr    <= '0;
            r_fb_wen     <= 1'b0;
            r_fb_dout    <= '0;
            r_gpu_start  <= 1'b0;
            r_frame_done <= 1'b0;
            r_fb_sel     <= 1'b0;
            r_pending    <= 1'b0;
            r_done_q     <= 1'b0;
            r_vsync_q    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_addr   <= w_clr_addr_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_wen     <= w_fb_wen_nxt;
            r_fb_dout    <= w_fb_dout_nxt;
            r_gpu_start  <= w_gpu_start_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_fb_sel     <= w_fb_sel_nxt;
            r_pending    <= w_pending_nxt;
            r_done_q     <= gpu_done;
            r_vsync_q    <= vsync;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_addr_nxt   = r_clr_addr;
        w_fb_addr_nxt    = r_fb_addr;
        w_fb_wen_nxt     = 1'b0;
        w_fb_dout_nxt    = r_fb_dout;
        w_gpu_start_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_fb_sel_nxt     = r_fb_sel;
        // One-deep queue: requests while busy collapse into a single flag
        w_pending_nxt    = r_pending | (frame_req & w_busy);

        case (r_state)
            S_IDLE: begin
                if (frame_req || r_pending) begin
                    w_state_nxt    = S_CLEAR;
                    w_pending_nxt  = 1'b0;
                    w_clr_addr_nxt = '0;
                    w_fb_addr_nxt  = '0;
                    w_fb_wen_nxt   = 1'b1;
                    w_fb_dout_nxt  = bg_color;
                end
            end
            S_CLEAR: begin
                if (r_clr_addr == c_LAST) begin
                    w_state_nxt     = S_START;
                    w_gpu_start_nxt = 1'b1;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                    w_fb_addr_nxt  = r_clr_addr + 1'b1;
                    w_fb_wen_nxt   = 1'b1;
                    w_fb_dout_nxt  = bg_color;
                end
            end
            S_START: begin
                w_state_nxt = S_RENDER;
            end
            S_RENDER: begin
                // Out-of-frame writes still update address/data but never strobe
                w_fb_addr_nxt = gpu_addr;
                w_fb_dout_nxt = gpu_dout;
                w_fb_wen_nxt  = gpu_wen & ({1'b0, gpu_addr} < c_N);
                if (w_done_rise) begin
                    w_state_nxt = S_SWAP_WAIT;
                end
            end
            S_SWAP_WAIT: begin
                if (w_vsync_rise) begin
                    w_state_nxt      = S_IDLE;
                    w_fb_sel_nxt     = ~r_fb_sel;
                    w_frame_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fb_addr    = r_fb_addr;
    assign fb_wen     = r_fb_wen;
    assign fb_dout    = r_fb_dout;
    assign gpu_start  = r_gpu_start;
    assign frame_done = r_frame_done;
    assign fb_sel     = r_fb_sel;
    assign disp_sel   = ~r_fb_sel;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_frame_sequencer                                              |
// | Brief    : Self-checking bench for frame_sequencer on an 8x4 frame.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_frame_sequencer;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int ADDR_W  = 6;
    localparam int COLOR_W = 6;
    localparam int N       = WIDTH * HEIGHT;

    logic               clk_tb = 1'b0;
    logic               reset;
    logic               frame_req;
    logic [COLOR_W-1:0] bg_color;
    logic               gpu_start;
    logic               gpu_done;
    logic [ADDR_W-1:0]  gpu_addr;
    logic               gpu_wen;
    logic [COLOR_W-1:0] gpu_dout;
    logic               vsync;
    logic [ADDR_W-1:0]  fb_addr;
    logic               fb_wen;
    logic [COLOR_W-1:0] fb_dout;
    logic               fb_sel;
    logic               disp_sel;
    logic               busy;
    logic               frame_done;

    int                 errors = 0;
    int                 checks = 0;
    logic               exp_sel;
    logic [COLOR_W-1:0] bg_drv;

    always #5 clk_tb = ~clk_tb;

    frame_sequencer #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ADDR_W  (ADDR_W),
        .COLOR_W (COLOR_W)
    ) dut (
        .clk        (clk_tb),
        .reset      (reset),
        .frame_req  (frame_req),
        .bg_color   (bg_color),
        .gpu_start  (gpu_start),
        .gpu_done   (gpu_done),
        .gpu_addr   (gpu_addr),
        .gpu_wen    (gpu_wen),
        .gpu_dout   (gpu_dout),
        .vsync      (vsync),
        .fb_addr    (fb_addr),
        .fb_wen     (fb_wen),
        .fb_dout    (fb_dout),
        .fb_sel     (fb_sel),
        .disp_sel   (disp_sel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic tick;
        @(posedge clk_tb);
        #1;
    endtask

    task automatic start_frame;
        bg_drv    = COLOR_W'($urandom);
        bg_color  = bg_drv;
        frame_req = 1'b1;
        tick;
        frame_req = 1'b0;
    endtask

    // Expects clear write 0 to be on the outputs on entry; leaves the DUT in RENDER.
    task automatic run_clear(input bit pulse_reqs);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (fb_wen !== 1'b1 || fb_addr !== ADDR_W'(k) || fb_dout !== bg_drv ||
                busy !== 1'b1 || gpu_start !== 1'b0) begin
                errors++;
                $display("FAIL clear_write k=%0d: got wen=%0b addr=%0d data=%0d busy=%0b start=%0b, want wen=1 addr=%0d data=%0d busy=1 start=0",
                         k, fb_wen, fb_addr, fb_dout, busy, gpu_start, k, bg_drv);
            end
            bg_drv    = COLOR_W'($urandom);
            bg_color  = bg_drv;
            frame_req = pulse_reqs && (k == 3 || k == 9 || k == 15);
            gpu_wen   = 1'b1;
            gpu_addr  = ADDR_W'($urandom_range(0, N-1));
            gpu_dout  = COLOR_W'($urandom);
            tick;
        end
        frame_req = 1'b0;
        checks++;
        if (gpu_start !== 1'b1 || fb_wen !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse: got start=%0b wen=%0b, want start=1 wen=0", gpu_start, fb_wen);
        end
        tick;
        checks++;
        if (gpu_start !== 1'b0 || fb_wen !== 1'b0) begin
            errors++;
            $display("FAIL start_end: got start=%0b wen=%0b, want start=0 wen=0", gpu_start, fb_wen);
        end
        gpu_wen = 1'b0;
    endtask

    task automatic render(input int cycles, input logic done_level);
        for (int i = 0; i < cycles; i++) begin
            int                 a;
            logic               w;
            logic               exp_w;
            logic [COLOR_W-1:0] d;
            if (i == 0) begin
                a = 5;  w = 1'b1; d = 6'h30;
            end else if (i == 1) begin
                a = 40; w = 1'b1; d = 6'h0C;
            end else begin
                a = int'($urandom_range(0, (1 << ADDR_W) - 1));
                w = 1'($urandom_range(0, 1));
                d = COLOR_W'($urandom);
            end
            gpu_addr = ADDR_W'(a);
            gpu_wen  = w;
            gpu_dout = d;
            gpu_done = done_level;
            tick;
            exp_w = w && (a < N);
            checks++;
            if (fb_wen !== exp_w || (exp_w && (fb_addr !== ADDR_W'(a) || fb_dout !== d))) begin
                errors++;
                $display("FAIL render_fwd i=%0d: got wen=%0b addr=%0d data=%0d, want wen=%0b addr=%0d data=%0d",
                         i, fb_wen, fb_addr, fb_dout, exp_w, a, d);
            end
        end
        gpu_wen = 1'b0;
    endtask

    // Raises gpu_done (optionally with a coincident vsync edge), then swaps on a later vsync.
    task automatic finish_frame(input int vs_delay, input logic coincident);
        int                 a;
        logic [COLOR_W-1:0] d;
        a        = int'($urandom_range(0, N-1));
        d        = COLOR_W'($urandom);
        gpu_addr = ADDR_W'(a);
        gpu_wen  = 1'b1;
        gpu_dout = d;
        gpu_done = 1'b1;
        vsync    = coincident;
        tick;
        checks++;
        if (fb_wen !== 1'b1 || fb_addr !== ADDR_W'(a) || fb_dout !== d) begin
            errors++;
            $display("FAIL done_cycle_write: got wen=%0b addr=%0d data=%0d, want wen=1 addr=%0d data=%0d",
                     fb_wen, fb_addr, fb_dout, a, d);
        end
        vsync = 1'b0;
        for (int i = 0; i < vs_delay; i++) begin
            gpu_addr = ADDR_W'($urandom_range(0, N-1));
            gpu_wen  = 1'b1;
            tick;
            checks++;
            if (fb_wen !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0 || fb_sel !== exp_sel) begin
                errors++;
                $display("FAIL swap_wait i=%0d: got wen=%0b busy=%0b done=%0b sel=%0b, want wen=0 busy=1 done=0 sel=%0b",
                         i, fb_wen, busy, frame_done, fb_sel, exp_sel);
            end
        end
        vsync   = 1'b1;
        gpu_wen = 1'b0;
        tick;
        exp_sel = ~exp_sel;
        checks++;
        if ({fb_sel, disp_sel, frame_done, busy} !== {exp_sel, ~exp_sel, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL swap: got sel=%0b disp=%0b frame_done=%0b busy=%0b, want sel=%0b disp=%0b frame_done=1 busy=0",
                     fb_sel, disp_sel, frame_done, busy, exp_sel, ~exp_sel);
        end
        vsync = 1'b0;
        tick;
        checks++;
        if (frame_done !== 1'b0 || fb_sel !== exp_sel) begin
            errors++;
            $display("FAIL frame_done_width: got frame_done=%0b sel=%0b, want frame_done=0 sel=%0b",
                     frame_done, fb_sel, exp_sel);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        frame_req = 1'b0;
        bg_color  = '0;
        bg_drv    = '0;
        gpu_done  = 1'b0;
        gpu_addr  = '0;
        gpu_wen   = 1'b0;
        gpu_dout  = '0;
        vsync     = 1'b0;
        exp_sel   = 1'b0;
        tick;
        tick;
        checks++;
        if ({fb_wen, fb_addr, fb_dout, gpu_start, busy, frame_done, fb_sel, disp_sel} !==
            {1'b0, {ADDR_W{1'b0}}, {COLOR_W{1'b0}}, 5'b00001}) begin
            errors++;
            $display("FAIL reset_state: got wen=%0b addr=%0d data=%0d start=%0b busy=%0b done=%0b sel=%0b disp=%0b, want 0 0 0 0 0 0 0 1",
                     fb_wen, fb_addr, fb_dout, gpu_start, busy, frame_done, fb_sel, disp_sel);
        end
        reset = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || fb_wen !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%0b wen=%0b, want 0 0", busy, fb_wen);
        end
    endtask

    task automatic test_frame_and_swap;
        start_frame;
        run_clear(1'b0);
        render(10, 1'b0);
        finish_frame(10, 1'b1);
    endtask

    task automatic test_stale_done;
        start_frame;
        run_clear(1'b0);
        render(6, 1'b1);
        render(2, 1'b0);
        finish_frame(5, 1'b0);
    endtask

    task automatic test_queue;
        start_frame;
        run_clear(1'b1);
        render(4, 1'b0);
        finish_frame(3, 1'b0);
        run_clear(1'b0);
        render(3, 1'b0);
        finish_frame(7, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick;
            checks++;
            if (busy !== 1'b0 || fb_wen !== 1'b0 || gpu_start !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_queue i=%0d: got busy=%0b wen=%0b start=%0b, want 0 0 0",
                         i, busy, fb_wen, gpu_start);
            end
        end
    endtask

    task automatic test_reset_mid;
        start_frame;
        for (int k = 0; k < 17; k++) begin
            frame_req = (k == 5);
            tick;
        end
        frame_req = 1'b0;
        checks++;
        if (fb_wen !== 1'b1 || fb_addr !== ADDR_W'(17)) begin
            errors++;
            $display("FAIL reset_mid_setup: got wen=%0b addr=%0d, want wen=1 addr=17", fb_wen, fb_addr);
        end
        reset = 1'b1;
        tick;
        reset   = 1'b0;
        exp_sel = 1'b0;
        checks++;
        if ({fb_wen, busy, fb_sel, disp_sel, frame_done, gpu_start} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_mid: got wen=%0b busy=%0b sel=%0b disp=%0b done=%0b start=%0b, want 0 0 0 1 0 0",
                     fb_wen, busy, fb_sel, disp_sel, frame_done, gpu_start);
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (busy !== 1'b0 || fb_wen !== 1'b0) begin
                errors++;
                $display("FAIL pending_cleared i=%0d: got busy=%0b wen=%0b, want 0 0", i, busy, fb_wen);
            end
        end
        start_frame;
        run_clear(1'b0);
        render(4, 1'b0);
        finish_frame(4, 1'b0);
    endtask

    initial begin
        test_reset;
        test_frame_and_swap;
        test_stale_done;
        test_queue;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
# frame_sequencer

Per-frame controller between the `game` triangle producer, the `gpu` rasterizer and the double-buffered 640x480x6-bit framebuffer. On each frame request it first clears the back buffer to a background colour, then pulses `gpu` start and forwards its pixel writes until `done`. It then waits for the display's vertical sync and swaps the front and back buffers. It owns the framebuffer write port, so clear writes and rasterizer writes never collide.

## Interface
- `WIDTH`, default 640: pixels per line.
- `HEIGHT`, default 480: lines per frame.
- `ADDR_W`, default 19: framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- `COLOR_W`, default 6: pixel width, RRGGBB.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `frame_req`  in  1  one-cycle request to render one frame.
- `bg_color`  in  COLOR_W  clear colour, sampled every CLEAR cycle.
- `gpu_start`  out  1  start pulse to `gpu`.
- `gpu_done`  in  1  `gpu` done level; only its rising edge is used.
- `gpu_addr`  in  ADDR_W  rasterizer write address.
- `gpu_wen`  in  1  rasterizer write enable.
- `gpu_dout`  in  COLOR_W  rasterizer write data.
- `vsync`  in  1  display frame boundary; only its rising edge is used.
- `fb_addr`  out  ADDR_W  framebuffer write address (registered).
- `fb_wen`  out  1  framebuffer write enable (registered).
- `fb_dout`  out  COLOR_W  framebuffer write data (registered).
- `fb_sel`  out  1  buffer currently being written (back buffer).
- `disp_sel`  out  1  buffer being displayed; always equal to ~`fb_sel`.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on each buffer swap.

## Operation
- N = WIDTH*HEIGHT. The block keeps registered copies of `gpu_done` and `vsync` and uses them for rising-edge detection.
- **IDLE**
  - `busy`=0.
  - Moves to CLEAR when `frame_req`=1 or `pending`=1.
  - On that transition it clears `pending`, sets `clr_addr`=0 and launches the first clear write.
- **CLEAR**
  - Issues one write per cycle: `fb_wen`=1, `fb_addr`=`clr_addr`, `fb_dout`=`bg_color`.
  - `clr_addr` counts 0..N-1 with no wrap. After address N-1 is issued the state moves to START.
  - `gpu_*` inputs are ignored.
- **START**
  - `gpu_start`=1 for exactly one cycle, `fb_wen`=0, then RENDER.
  - A `gpu_done` edge seen in START is ignored, because `done` may still be high from the previous frame.
- **RENDER**
  - Registers `gpu_addr`/`gpu_wen`/`gpu_dout` straight through to the `fb_*` outputs.
  - A write is suppressed (`fb_wen`=0) if `gpu_addr` >= N.
  - A rising edge of `gpu_done` moves to SWAP_WAIT. A write presented in that same cycle is still forwarded.
- **SWAP_WAIT**
  - `fb_wen`=0 and all `gpu_wen` writes are dropped.
  - A rising edge of `vsync` toggles `fb_sel` and `disp_sel`, pulses `frame_done`, and moves to IDLE.
  - A `vsync` edge that coincides with the `gpu_done` edge does not count; the swap waits for the next `vsync` edge.
- **Request queueing**
  - `frame_req` while `busy`=1 sets a one-deep `pending` flag.
  - Further requests while `pending`=1 are dropped.
  - A request in the same cycle as the `frame_done` pulse sets `pending`.
- **Reset**
  - Can be asserted in any state, including mid-CLEAR or mid-RENDER. The next edge forces IDLE.
  - Outputs after reset: `fb_wen`=0, `fb_addr`=0, `fb_dout`=0, `gpu_start`=0, `busy`=0, `frame_done`=0, `fb_sel`=0, `disp_sel`=1.
  - `pending`=0, `clr_addr`=0, and both edge-detect registers=0.

## Timing
- Clear write k (k=0..N-1) appears on `fb_*` during the k-th cycle after the edge that leaves IDLE. `fb_wen` is therefore high for exactly N consecutive cycles.
- `gpu_start` is high in the cycle immediately after the last clear write: one cycle, with no gap or overlap.
- The latency from `frame_req` to the first `fb_wen` is 1 cycle.
- RENDER forwarding latency is 1 cycle: a `gpu_*` write at edge t appears on `fb_*` after edge t+1.
- A `gpu_done` rising edge sampled at edge t makes the state SWAP_WAIT after edge t.
- A `vsync` edge sampled at edge t in SWAP_WAIT: `fb_sel` toggles and `frame_done` is high for the cycle after edge t. `busy` falls in that same cycle.

## Test plan
1. **Full-frame clear.** WIDTH=8, HEIGHT=4, `bg_color`=6'b000011; pulse `frame_req`.
   -> `fb_wen` high for exactly 32 cycles, addresses 0..31 in order, data 3.
   -> Then `gpu_start` high for exactly 1 cycle.
2. **Render forwarding and bounds.** In RENDER, drive writes (5,6'h30) and (40,6'h0C) with N=32.
   -> Address 5 is written one cycle later.
   -> The write to address 40 is suppressed (`fb_wen`=0).
3. **Done edge and swap.** Raise `gpu_done`; raise `vsync` in the same cycle, then again 10 cycles later.
   -> No swap on the first `vsync`.
   -> On the second: `fb_sel` 0->1, `disp_sel` 1->0, one `frame_done` pulse, `busy`=0.
4. **Stale done.** Hold `gpu_done`=1 from the previous frame through START into RENDER.
   -> The block stays in RENDER until `gpu_done` falls and then rises again.
5. **Request queueing.** Pulse `frame_req` 3 times during CLEAR.
   -> Exactly one further frame runs after `frame_done`; two frames total, then IDLE.
6. **Reset mid-operation.** Assert `reset` for 1 cycle at clear address 17.
   -> Next cycle: `fb_wen`=0, `busy`=0, `fb_sel`=0, `disp_sel`=1.
   -> A new `frame_req` restarts the clear at address 0.
